mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative RV32M multiply/divide sequencer beside the Execute stage. It accepts one M-extension operation (funct3-selected) from the Execute operands and runs a radix-2 shift-add multiply or a restoring divide over XLEN cycles. While it runs it stalls the pipeline, then presents the result for one cycle. It owns its own datapath and does not borrow the ALU; the only coupling is the start/stall/done handshake with the pipeline control.

## Interface
- XLEN, 32, operand/result width; must be even and ≥ 8
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  request; sampled only in IDLE
- i_flush  in  1  abort current operation (pipeline flush)
- i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1  in  XLEN  operand A (multiplicand / dividend)
- i_rs2  in  XLEN  operand B (multiplier / divisor)
- o_stall  out  1  hold upstream stages
- o_busy  out  1  state != IDLE
- o_done  out  1  result valid, one-cycle pulse
- o_result  out  XLEN  result; held until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE, i_start=1, i_flush=0:
  - latch funct3 and operand signs
  - latch |A| and |B| (signedness per op: MULH/DIV/REM both signed, MULHSU A only, others unsigned)
  - clear iteration counter
  - go CALC, or go DONE directly on a special case
- Special cases, divide ops only:
  - B=0: quotient = all ones, remainder = A
  - signed overflow (DIV/REM, A = 2^(XLEN-1), B = all ones): quotient = A, remainder = 0
- CALC, multiply: 2·XLEN-bit product register; one conditional add plus shift-right per cycle.
- CALC, divide: XLEN-bit remainder and quotient registers; one trial subtract plus shift-left per cycle.
- Counter runs 0..XLEN-1. On the edge with counter = XLEN-1:
  - perform the last iteration
  - apply sign correction (negate product if signs differ; quotient negated if signs differ; remainder takes the dividend's sign)
  - load o_result and go DONE
- o_result selection: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2·XLEN-1:XLEN].
- DONE: o_done=1 for exactly one cycle, then go IDLE unconditionally.
- i_start outside IDLE: ignored.
- i_flush in any state: next state IDLE; o_done is not asserted; o_result unchanged.
- i_flush and i_start in the same cycle: flush wins and the request is not accepted.
- o_stall = (IDLE & i_start & ~i_flush) | CALC. It is the only combinational input-to-output path. o_stall is 0 in DONE, so the pipeline advances and captures o_result.
- Reset (async, any state, including mid-operation): state IDLE, counter 0, o_result 0, o_done 0, o_busy 0, o_stall 0 (while i_start=0). Internal registers are cleared.
- Widths: counter is $clog2(XLEN) bits. Arithmetic is two's complement, modulo 2^XLEN. Negation of 2^(XLEN-1) wraps to itself.

## Timing
- Request accepted at the rising edge ending cycle T (i_start high during T).
- Normal ops: CALC occupies cycles T+1..T+XLEN; o_done and a valid o_result appear in cycle T+XLEN+1 (33 cycles after the request for XLEN=32).
- Special cases: o_done in cycle T+1.
- Earliest next accepted start: cycle T+XLEN+2 (back in IDLE). The start in DONE's cycle is ignored.
- o_stall is high from cycle T through T+XLEN inclusive, and low in the done cycle.
- All outputs except o_stall are registered.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) -> o_done in cycle T+33, o_result 0xFFFFFFEB; MULH of the same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide sign handling:
  - DIV −7 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF
  - DIVU 100 / 7 -> 14; REMU -> 2
- Special cases:
  - DIV 5 / 0 -> 0xFFFFFFFF at T+1
  - REMU 5 / 0 -> 5
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0
- Flush and restart: i_flush at counter 10 -> IDLE next cycle, no o_done, o_result unchanged; a new start accepted after it completes normally. Flush and start together in IDLE -> not accepted, o_stall 0.
- Reset and protocol:
  - i_rst_n low mid-CALC -> all outputs 0 immediately, state IDLE
  - i_start held high through a whole operation -> a second operation starts only in cycle T+34, and o_done pulses exactly once per accepted start

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer with stall/done handshake
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              negA, negB;
  logic [XLEN-1:0]   mcand, divisor, rem, quo;
  logic [2*XLEN-1:0] prod;

  // operand conditioning at request time
  logic            signedA, signedB, aNeg, bNeg, accept, divZero, divOvf;
  logic [XLEN-1:0] absA, absB, specialRes;
  assign signedA    = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1] ^ i_funct3[0]);
  assign signedB    = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
  assign aNeg       = signedA & i_rs1[XLEN-1];
  assign bNeg       = signedB & i_rs2[XLEN-1];
  assign absA       = aNeg ? -i_rs1 : i_rs1;
  assign absB       = bNeg ? -i_rs2 : i_rs2;
  assign divZero    = i_funct3[2] & (i_rs2 == '0);
  assign divOvf     = i_funct3[2] & ~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2);
  assign specialRes = divZero ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
  assign accept     = (state == IDLE) & i_start & ~i_flush;

  assign o_stall = accept | (state == CALC);
  assign o_busy  = state != IDLE;
  assign o_done  = state == DONE;

  // one shift-add and one restoring-divide step per cycle, plus final sign correction
  logic [XLEN:0]     addSum, shifted;
  logic              fits;
  logic [2*XLEN-1:0] prodNext, prodFinal;
  logic [XLEN-1:0]   remNext, quoNext, remFinal, quoFinal, calcRes;
  always_comb begin
    addSum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    prodNext  = {addSum, prod[XLEN-1:1]};
    shifted   = {rem, quo[XLEN-1]};
    fits      = shifted >= {1'b0, divisor};
    remNext   = fits ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
    quoNext   = {quo[XLEN-2:0], fits};
    prodFinal = (negA ^ negB) ? -prodNext : prodNext;
    quoFinal  = (negA ^ negB) ? -quoNext : quoNext;
    remFinal  = negA ? -remNext : remNext;
    calcRes   = op[2] ? (op[1] ? remFinal : quoFinal)
                      : ((op[1:0] == 2'b00) ? prodFinal[XLEN-1:0] : prodFinal[2*XLEN-1:XLEN]);
  end

  // sequencer: flush beats everything, special divides skip straight to DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      mcand    <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      prod     <= '0;
      o_result <= '0;
    end else if (i_flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (i_start) begin
        op      <= i_funct3;
        negA    <= aNeg;
        negB    <= bNeg;
        mcand   <= absA;
        divisor <= absB;
        quo     <= absA;
        rem     <= '0;
        prod    <= {{XLEN{1'b0}}, absB};
        cnt     <= '0;
        if (divZero | divOvf) begin
          o_result <= specialRes;
          state    <= DONE;
        end else begin
          state <= CALC;
        end
      end
    end else if (state == CALC) begin
      prod <= prodNext;
      rem  <= remNext;
      quo  <= quoNext;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(XLEN - 1)) begin
        o_result <= calcRes;
        state    <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq
module tb_mdu_seq;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_flush = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_result;
  int vectors = 0, miscompares = 0;

  mdu_seq #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_flush(i_flush),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  // issue one request, wait (bounded) for done; lat counts cycles after the request cycle
  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic stallOk);
    @(negedge i_clk);
    i_funct3 = f; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
    #1 stallOk = o_stall;
    @(negedge i_clk);
    i_start = 1'b0;
    lat = 1;
    while (!o_done && lat < 40) begin
      stallOk &= o_stall;
      @(negedge i_clk);
      lat++;
    end
    stallOk &= ~o_stall;
    res = o_result;
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({o_stall, o_busy, o_done, o_result} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_state: got stall=%b busy=%b done=%b result=%h, want all 0", o_stall, o_busy, o_done, o_result);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic runTable(input string name, input logic [2:0] f[], input logic [31:0] a[],
                          input logic [31:0] b[], input logic [31:0] exp[], input int expLat);
    int lat;
    logic [31:0] res;
    logic stallOk;
    for (int i = 0; i < f.size(); i++) begin
      runOp(f[i], a[i], b[i], lat, res, stallOk);
      vectors++;
      if (res !== exp[i]) begin
        miscompares++;
        $display("FAIL %s_result[%0d]: got %h, want %h", name, i, res, exp[i]);
      end
      vectors++;
      if (lat !== expLat) begin
        miscompares++;
        $display("FAIL %s_latency[%0d]: got %0d, want %0d", name, i, lat, expLat);
      end
      vectors++;
      if (stallOk !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_stall[%0d]: got %b, want 1 (high until done, low in done)", name, i, stallOk);
      end
      @(negedge i_clk);
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_done_pulse[%0d]: got done=%b busy=%b, want 0 0", name, i, o_done, o_busy);
      end
    end
  endtask

  task automatic test_mul;
    runTable("mul", '{3'b000, 3'b001, 3'b011, 3'b010},
             '{32'h7, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF},
             '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF},
             '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF}, 33);
  endtask

  task automatic test_div;
    runTable("div", '{3'b100, 3'b110, 3'b101, 3'b111},
             '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100},
             '{32'd2, 32'd2, 32'd7, 32'd7},
             '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2}, 33);
  endtask

  task automatic test_special;
    runTable("special", '{3'b100, 3'b111, 3'b100, 3'b110},
             '{32'd5, 32'd5, 32'h80000000, 32'h80000000},
             '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
             '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0}, 1);
  endtask

  task automatic test_flush;
    logic [31:0] prev, res;
    int lat, dones;
    logic stallOk;
    prev = o_result;
    @(negedge i_clk);
    i_funct3 = 3'b011; i_rs1 = 32'h12345678; i_rs2 = 32'h9ABCDEF0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_stall !== 1'b0 || o_result !== prev) begin
      miscompares++;
      $display("FAIL flush_idle: got busy=%b done=%b stall=%b result=%h, want 0 0 0 %h", o_busy, o_done, o_stall, o_result, prev);
    end
    dones = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    vectors++;
    if (dones !== 0 || o_result !== prev) begin
      miscompares++;
      $display("FAIL flush_no_done: got dones=%0d result=%h, want 0 %h", dones, o_result, prev);
    end
    runOp(3'b101, 32'd100, 32'd7, lat, res, stallOk);
    vectors++;
    if (res !== 32'd14 || lat !== 33) begin
      miscompares++;
      $display("FAIL flush_restart: got result=%h lat=%0d, want 0000000e 33", res, lat);
    end
    @(negedge i_clk);
    i_start = 1'b1; i_flush = 1'b1;
    #1;
    vectors++;
    if (o_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_stall: got %b, want 0", o_stall);
    end
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start_busy: got %b, want 0", o_busy);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_funct3 = 3'b000; i_rs1 = 32'd3; i_rs2 = 32'd5; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    vectors++;
    if (o_busy !== 1'b1 || o_result === 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got busy=%b result=%h, want busy 1 and nonzero result", o_busy, o_result);
    end
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_stall, o_busy, o_done, o_result} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got stall=%b busy=%b done=%b result=%h, want all 0", o_stall, o_busy, o_done, o_result);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: got busy=%b done=%b, want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_back_to_back;
    int dones, firstK, secondK;
    dones = 0; firstK = 0; secondK = 0;
    @(negedge i_clk);
    i_funct3 = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7; i_start = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        dones++;
        if (firstK == 0) firstK = k; else secondK = k;
      end
      if (k == 34) begin
        #1;
        vectors++;
        if (o_busy !== 1'b0 || o_stall !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_idle_gap: got busy=%b stall=%b, want 0 1", o_busy, o_stall);
        end
      end
      if (k == 35) begin
        vectors++;
        if (o_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart: got busy=%b, want 1", o_busy);
        end
        i_start = 1'b0;
      end
    end
    vectors++;
    if (dones !== 2 || firstK !== 33 || secondK !== 67) begin
      miscompares++;
      $display("FAIL b2b_done_pulses: got %0d at %0d,%0d, want 2 at 33,67", dones, firstK, secondK);
    end
    vectors++;
    if (o_result !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_result: got %h, want 0000000e", o_result);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
